sample_readback: RTL and testbench
==================================

// Module: sample_readback
// PURPOSE
//  Captures the signed 16-bit summed waveform (finalSum) into an on-chip buffer and returns it to the host through a PipeOut endpoint.
//  It is the FPGA->host counterpart of the PipeIn control path that loads amps/offsets/phasewords.
//  Host arms it via a WireIn bit. It waits for a trigger, fills DEPTH words at a programmable decimation, then drains on pipe reads.
// PARAMETERS
//  DEPTH_LOG2  10  buffer depth = 2**DEPTH_LOG2 words (1024)
//  WIDTH       16  sample / pipe word width
// PORTS
//  clk           in   1           ti_clk domain; all inputs synchronous to it
//  reset_n       in   1           asynchronous, active-low reset
//  arm           in   1           one-cycle pulse: flush buffer, enter ARMED
//  decim         in   8           store every decim-th valid sample; 0 treated as 1
//  trig_level    in   WIDTH       signed trigger threshold (used only with READBACK_TRIG_EN)
//  sample_in     in   WIDTH       signed waveform sample
//  sample_valid  in   1           sample_in qualifier
//  ep_read       in   1           PipeOut read strobe, one word per asserted cycle
//  ep_datain     out  WIDTH       PipeOut data word
//  state         out  2           0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//  fill_count    out  DEPTH_LOG2+1  words stored and not yet read
//  underrun      out  1           sticky: read issued with no data available
// BEHAVIOUR
//  Reset: state=IDLE, pointers=0, fill_count=0, ep_datain=0, underrun=0, decimation counter=0. Reset mid-capture discards all data.
//  FSM:
//   IDLE->ARMED on arm.
//   ARMED->CAPTURE on trigger. The trigger sample is the first word stored, and the decimation counter restarts at it.
//   CAPTURE->DONE on the cycle the DEPTH-th word is written.
//   DONE->IDLE on the read that takes fill_count 1->0.
//  arm in ARMED or DONE: flush (pointers and fill_count to 0), clear underrun, go to ARMED. arm in CAPTURE: ignored.
//  Capture: counts valid samples; writes when count hits decim-1, then count wraps to 0. sample_valid low: no count, no write.
//  Writes happen only in CAPTURE. The buffer never wraps and never overwrites: exactly DEPTH words per capture.
//  Readback is first-word-fall-through:
//   In DONE, ep_datain shows word rd_ptr (word 0 on the first cycle of DONE).
//   ep_read high at edge N -> rd_ptr+1 and fill_count-1 after edge N, and ep_datain shows the next word from cycle N+1. Back-to-back reads every cycle are supported.
//  ep_read outside DONE, or with fill_count=0: no pointer change, ep_datain=0, underrun<=1.
//  arm and ep_read in the same cycle: arm wins, the read is discarded, underrun is not set.
//  Read and write never overlap, because reads are honoured only in DONE.
//  Last read: ep_datain=0 from the following cycle and state=IDLE.
//  Width: fill_count is DEPTH_LOG2+1 bits so it can hold DEPTH. The decimation counter is 8 bits. The trigger compare is signed.
// CONFIGURATION
//  `define READBACK_TRIG_EN:
//   Trigger in ARMED = rising crossing, i.e. previous valid sample < trig_level and current valid sample >= trig_level (signed). The first valid sample after arm only primes "previous".
//  Undefined:
//   Trigger = first valid sample in ARMED. trig_level is ignored, and no crossing logic is synthesised.
// STRUCTURE
//  readback_defs.vh (shared include): state encodings RB_IDLE/RB_ARMED/RB_CAPTURE/RB_DONE; WireIn bit index for arm; PipeOut address 8'hA0.
//  Sub-module sample_readback_ram: simple dual-port, synchronous write, synchronous read, 2**DEPTH_LOG2 x WIDTH (block RAM).
//  The top module holds the FSM, decimator, pointers and the FWFT prefetch register.
// TESTING
//  1. Reset, then ep_read x3 -> ep_datain=0, underrun=1, state=IDLE, fill_count=0.
//  2. decim=1, no macro, arm, ramp 0,1,2,... every cycle -> state DONE after 1024 writes; 1024 back-to-back reads return 0..1023; then IDLE and ep_datain=0.
//  3. decim=4, ramp with sample_valid toggling -> stored words are ramp values 0,4,8,...; fill_count=1024 at DONE.
//  4. READBACK_TRIG_EN, trig_level=100, sine from -500 -> word 0 is the first sample >=100 after a sample <100; the preceding falling crossing is ignored.
//  5. Re-arm in DONE after 10 reads -> fill_count=0, underrun cleared, ARMED; arm pulsed during CAPTURE -> capture completes unaffected.
//  6. reset_n low mid-CAPTURE at word 500 -> immediate IDLE, fill_count=0; arm again -> fresh capture starts at word 0.

Source files
------------

// File: rtl/sample_readback_pkg.sv
// sample_readback_pkg: shared state encodings and host-interface constants for the readback path
package sample_readback_pkg;

    typedef enum logic [1:0] {
        RB_IDLE    = 2'd0,
        RB_ARMED   = 2'd1,
        RB_CAPTURE = 2'd2,
        RB_DONE    = 2'd3
    } rb_state_t;

    localparam int        RB_ARM_WIRE_BIT = 0;
    localparam logic [7:0] RB_PIPE_OUT_ADDR = 8'hA0;

endpackage

// File: rtl/sample_readback_ram.sv
// sample_readback_ram: simple dual-port block RAM, synchronous write and synchronous read
module sample_readback_ram #(
    parameter int AW = 10,
    parameter int W  = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [0:(1<<AW)-1];

    // registered write and registered read port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sample_readback.sv
// sample_readback: triggered, decimated capture of the summed waveform, drained FWFT through a PipeOut
// Optional feature: `define READBACK_TRIG_EN selects a signed rising-crossing trigger on trig_level;
// without it the first valid sample after arm triggers.
module sample_readback
    import sample_readback_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  arm,
    input  logic [7:0]            decim,
    input  logic [WIDTH-1:0]      trig_level,
    input  logic [WIDTH-1:0]      sample_in,
    input  logic                  sample_valid,
    input  logic                  ep_read,
    output logic [WIDTH-1:0]      ep_datain,
    output logic [1:0]            state,
    output logic [DEPTH_LOG2:0]   fill_count,
    output logic                  underrun
);

    localparam logic [DEPTH_LOG2:0] FILL_ONE = 1;

    rb_state_t             st;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_addr;
    logic [7:0]            dcnt, dlim;
    logic [WIDTH-1:0]      ram_q;
    logic                  arm_ok, rd_ok, trig, hit, wr_en;

    assign dlim    = (decim == 8'd0) ? 8'd0 : decim - 8'd1;
    assign arm_ok  = arm && st != RB_CAPTURE;
    assign rd_ok   = ep_read && !arm && st == RB_DONE && fill_count != '0;
    assign hit     = sample_valid && dcnt == dlim;
    assign wr_en   = (st == RB_ARMED && !arm && trig) || (st == RB_CAPTURE && hit);
    // the RAM is addressed one word ahead on a read so ram_q already holds the next word
    assign rd_addr = rd_ptr + DEPTH_LOG2'(rd_ok);
    assign ep_datain = (st == RB_DONE && fill_count != '0) ? ram_q : '0;
    assign state   = st;

`ifdef READBACK_TRIG_EN
    logic signed [WIDTH-1:0] prev;
    logic                    primed;

    assign trig = sample_valid && primed && prev < $signed(trig_level) && $signed(sample_in) >= $signed(trig_level);

    // remember the last valid sample seen while armed; the first one after arm only primes it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev   <= '0;
            primed <= 1'b0;
        end else if (arm_ok) begin
            primed <= 1'b0;
        end else if (st == RB_ARMED && sample_valid) begin
            prev   <= sample_in;
            primed <= 1'b1;
        end
    end
`else
    logic unused_trig_level;

    assign unused_trig_level = ^trig_level;
    assign trig = sample_valid;
`endif

    sample_readback_ram #(.AW(DEPTH_LOG2), .W(WIDTH)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (sample_in),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    // capture/readback FSM with decimator, pointers, fill level and sticky underrun
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st         <= RB_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            dcnt       <= '0;
            underrun   <= 1'b0;
        end else if (arm_ok) begin
            st         <= RB_ARMED;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            dcnt       <= '0;
            if (st != RB_IDLE) underrun <= 1'b0;
        end else begin
            if (ep_read && !arm && !rd_ok) underrun <= 1'b1;
            case (st)
                RB_ARMED: if (trig) begin
                    st         <= RB_CAPTURE;
                    wr_ptr     <= wr_ptr + 1'b1;
                    fill_count <= fill_count + 1'b1;
                    dcnt       <= '0;
                end
                RB_CAPTURE: if (sample_valid) begin
                    dcnt <= hit ? 8'd0 : dcnt + 8'd1;
                    if (hit) begin
                        wr_ptr     <= wr_ptr + 1'b1;
                        fill_count <= fill_count + 1'b1;
                        if (wr_ptr == '1) st <= RB_DONE;
                    end
                end
                RB_DONE: if (rd_ok) begin
                    rd_ptr     <= rd_ptr + 1'b1;
                    fill_count <= fill_count - 1'b1;
                    if (fill_count == FILL_ONE) st <= RB_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_readback.sv
// tb_sample_readback: directed self-checking bench for sample_readback
module tb_sample_readback;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        arm = 1'b0;
    logic [7:0]  decim = 8'd1;
    logic [15:0] trig_level = 16'd0;
    logic [15:0] sample_in = 16'd0;
    logic        sample_valid = 1'b0;
    logic        ep_read = 1'b0;
    logic [15:0] ep_datain;
    logic [1:0]  state;
    logic [10:0] fill_count;
    logic        underrun;

    int n_cmp = 0;
    int n_bad = 0;

    sample_readback dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .arm          (arm),
        .decim        (decim),
        .trig_level   (trig_level),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .ep_read      (ep_read),
        .ep_datain    (ep_datain),
        .state        (state),
        .fill_count   (fill_count),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state); end
        n_cmp++; if (fill_count !== 11'd0) begin n_bad++; $display("FAIL reset_fill got %0d want 0", fill_count); end
        n_cmp++; if (ep_datain !== 16'd0) begin n_bad++; $display("FAIL reset_data got %h want 0000", ep_datain); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun got %b want 0", underrun); end
        ep_read = 1'b1;
        repeat (3) tick();
        ep_read = 1'b0;
        n_cmp++; if (ep_datain !== 16'd0) begin n_bad++; $display("FAIL idle_read_data got %h want 0000", ep_datain); end
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL idle_read_underrun got %b want 1", underrun); end
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL idle_read_state got %0d want 0", state); end
        n_cmp++; if (fill_count !== 11'd0) begin n_bad++; $display("FAIL idle_read_fill got %0d want 0", fill_count); end
    endtask

    task automatic test_ramp_decim1();
        decim = 8'd1;
        pulse_arm();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL d1_armed got %0d want 1", state); end
        for (int i = 0; i < 1024; i++) begin
            sample_in = 16'(i);
            sample_valid = 1'b1;
            tick();
            if (i == 1022) begin
                n_cmp++; if (state !== 2'd2 || fill_count !== 11'd1023) begin n_bad++; $display("FAIL d1_pre_done got state %0d fill %0d want 2/1023", state, fill_count); end
            end
        end
        sample_valid = 1'b0;
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL d1_done got %0d want 3", state); end
        n_cmp++; if (fill_count !== 11'd1024) begin n_bad++; $display("FAIL d1_fill got %0d want 1024", fill_count); end
        for (int i = 0; i < 1024; i++) begin
            n_cmp++; if (ep_datain !== 16'(i)) begin n_bad++; $display("FAIL d1_word[%0d] got %h want %h", i, ep_datain, 16'(i)); end
            if (i == 512) begin
                n_cmp++; if (fill_count !== 11'd512) begin n_bad++; $display("FAIL d1_mid_fill got %0d want 512", fill_count); end
            end
            ep_read = 1'b1;
            tick();
        end
        ep_read = 1'b0;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL d1_idle got %0d want 0", state); end
        n_cmp++; if (ep_datain !== 16'd0) begin n_bad++; $display("FAIL d1_after_data got %h want 0000", ep_datain); end
        n_cmp++; if (fill_count !== 11'd0) begin n_bad++; $display("FAIL d1_after_fill got %0d want 0", fill_count); end
    endtask

    task automatic test_decim4();
        int v;
        int cyc;
        v = 0;
        cyc = 0;
        decim = 8'd4;
        pulse_arm();
        while (state !== 2'd3 && cyc < 20000) begin
            sample_in = 16'(v);
            sample_valid = (cyc % 2) == 0;
            tick();
            if (sample_valid) v++;
            cyc++;
        end
        sample_valid = 1'b0;
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL d4_done got %0d want 3 after %0d cycles", state, cyc); end
        n_cmp++; if (fill_count !== 11'd1024) begin n_bad++; $display("FAIL d4_fill got %0d want 1024", fill_count); end
        n_cmp++; if (v !== 4093) begin n_bad++; $display("FAIL d4_samples_used got %0d want 4093", v); end
        for (int i = 0; i < 1024; i++) begin
            n_cmp++; if (ep_datain !== 16'(4 * i)) begin n_bad++; $display("FAIL d4_word[%0d] got %h want %h", i, ep_datain, 16'(4 * i)); end
            ep_read = 1'b1;
            tick();
        end
        ep_read = 1'b0;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL d4_idle got %0d want 0", state); end
    endtask

    task automatic test_trigger();
        logic [15:0] pre [12];
        logic [15:0] exp0;
        int n_pre;
        decim = 8'd1;
        trig_level = 16'd100;
`ifdef READBACK_TRIG_EN
        pre = '{16'd300, 16'd200, 16'd150, 16'd50, -16'sd100, -16'sd500,
                -16'sd200, 16'd50, 16'd99, 16'd100, 16'd0, 16'd0};
        n_pre = 10;
        exp0 = 16'd100;
`else
        pre = '{-16'sd500, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        n_pre = 1;
        exp0 = -16'sd500;
`endif
        pulse_arm();
        sample_in = 16'h7777;
        sample_valid = 1'b0;
        repeat (3) tick();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL trig_wait_invalid got %0d want 1", state); end
        for (int i = 0; i < n_pre; i++) begin
            if (i == n_pre - 1) begin
                n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL trig_still_armed got %0d want 1", state); end
            end
            sample_in = pre[i];
            sample_valid = 1'b1;
            tick();
        end
        n_cmp++; if (state !== 2'd2 || fill_count !== 11'd1) begin n_bad++; $display("FAIL trig_capture got state %0d fill %0d want 2/1", state, fill_count); end
        for (int i = 0; i < 1023; i++) begin
            sample_in = 16'(1000 + i);
            tick();
        end
        sample_valid = 1'b0;
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL trig_done got %0d want 3", state); end
        for (int i = 0; i < 1024; i++) begin
            n_cmp++; if (ep_datain !== ((i == 0) ? exp0 : 16'(999 + i))) begin n_bad++; $display("FAIL trig_word[%0d] got %h want %h", i, ep_datain, (i == 0) ? exp0 : 16'(999 + i)); end
            ep_read = 1'b1;
            tick();
        end
        ep_read = 1'b0;
    endtask

    task automatic test_rearm();
        decim = 8'd0;
        pulse_arm();
        for (int i = 0; i < 1024; i++) begin
            sample_in = 16'(i);
            sample_valid = 1'b1;
            arm = (i == 200);
            ep_read = (i == 300);
            tick();
        end
        arm = 1'b0;
        ep_read = 1'b0;
        sample_valid = 1'b0;
        n_cmp++; if (state !== 2'd3 || fill_count !== 11'd1024) begin n_bad++; $display("FAIL rearm_done got state %0d fill %0d want 3/1024", state, fill_count); end
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL capture_read_underrun got %b want 1", underrun); end
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (ep_datain !== 16'(i)) begin n_bad++; $display("FAIL rearm_word[%0d] got %h want %h", i, ep_datain, 16'(i)); end
            ep_read = 1'b1;
            tick();
        end
        ep_read = 1'b0;
        n_cmp++; if (ep_datain !== 16'd10 || fill_count !== 11'd1014) begin n_bad++; $display("FAIL rearm_after10 got data %h fill %0d want 000a/1014", ep_datain, fill_count); end
        arm = 1'b1;
        ep_read = 1'b1;
        tick();
        arm = 1'b0;
        ep_read = 1'b0;
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL rearm_state got %0d want 1", state); end
        n_cmp++; if (fill_count !== 11'd0) begin n_bad++; $display("FAIL rearm_fill got %0d want 0", fill_count); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL rearm_underrun got %b want 0", underrun); end
        n_cmp++; if (ep_datain !== 16'd0) begin n_bad++; $display("FAIL rearm_data got %h want 0000", ep_datain); end
    endtask

    task automatic test_reset_mid_capture();
        decim = 8'd1;
        for (int i = 0; i < 500; i++) begin
            sample_in = 16'(5000 + i);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        n_cmp++; if (state !== 2'd2 || fill_count !== 11'd500) begin n_bad++; $display("FAIL mid_capture got state %0d fill %0d want 2/500", state, fill_count); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (state !== 2'd0 || fill_count !== 11'd0 || ep_datain !== 16'd0) begin n_bad++; $display("FAIL async_reset got state %0d fill %0d data %h want 0/0/0000", state, fill_count, ep_datain); end
        tick();
        #3 reset_n = 1'b1;
        tick();
        pulse_arm();
        for (int i = 0; i < 1024; i++) begin
            sample_in = 16'(7000 + i);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        n_cmp++; if (state !== 2'd3 || fill_count !== 11'd1024) begin n_bad++; $display("FAIL post_reset_done got state %0d fill %0d want 3/1024", state, fill_count); end
        for (int i = 0; i < 1024; i++) begin
            n_cmp++; if (ep_datain !== 16'(7000 + i)) begin n_bad++; $display("FAIL post_reset_word[%0d] got %h want %h", i, ep_datain, 16'(7000 + i)); end
            ep_read = 1'b1;
            tick();
        end
        ep_read = 1'b0;
        n_cmp++; if (state !== 2'd0 || ep_datain !== 16'd0) begin n_bad++; $display("FAIL post_reset_idle got state %0d data %h want 0/0000", state, ep_datain); end
    endtask

    initial begin
        test_reset();
        test_ramp_decim1();
        test_decim4();
        test_trigger();
        test_rearm();
        test_reset_mid_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
